// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C single-word read receiver:
//   - state_t    : receiver FSM state encoding
//   - ERR_*      : values reported on error_code
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // not armed, waiting for enable
        ST_ARMED = 2'd1,   // armed, waiting for the first SCL rise
        ST_HIGH  = 2'd2,   // SCL high after a sampled bit
        ST_LOW   = 2'd3    // SCL low between bits
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;   // transfer completed normally
    localparam logic [1:0] ERR_START = 2'b01;   // SDA fell while SCL high
    localparam logic [1:0] ERR_STOP  = 2'b10;   // SDA rose while SCL high

endpackage : i2c_pkg

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Glitch filter for one raw I2C line. The filtered output only adopts the raw
// value after FILTER_LEN consecutive samples that differ from the current
// output; any sample agreeing with the output restarts the count.
//
// Ports:
//   i_clock     system clock (rising edge)
//   i_reset_n   asynchronous active-low reset (output resets to 1, bus idle)
//   i_raw       raw line sample
//   o_filtered  filtered line value
// -----------------------------------------------------------------------------
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_filtered
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds how many differing samples were already seen; the sample
    // that brings the run to FILTER_LEN flips the output directly.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out <= 1'b1;
            r_cnt <= '0;
        end else if (i_raw == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_out <= i_raw;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_filtered = r_out;

endmodule : i2c_line_filter

// File: rtl/i2c_slave_read_word.sv
// -----------------------------------------------------------------------------
// i2c_slave_read_word
// Receives one DATA_WIDTH-bit word from a raw I2C bus after a one-cycle
// enable. Bits are sampled on filtered SCL rising edges; the word completes
// on the SCL fall after the last bit. An SDA change while SCL is high
// (START/STOP condition) ends the transfer with an error.
//
// Parameters:
//   DATA_WIDTH  bits per transfer (1..32)
//   MSB_FIRST   1: first bit lands in data[DATA_WIDTH-1]; 0: in data[0]
//   FILTER_LEN  consecutive equal samples before a filtered line changes
//
// Ports:
//   clock       system clock (rising edge)
//   reset_n     asynchronous active-low reset
//   enable      one-cycle arm request, honoured only when idle
//   abort       return to idle, no finish pulse, data/error kept
//   scl, sda    raw I2C lines
//   data        last successfully completed word
//   finish      one-cycle pulse at end of transfer (success or error)
//   error       last transfer ended abnormally
//   error_code  ERR_NONE / ERR_START / ERR_STOP
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module i2c_slave_read_word
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int FILTER_LEN = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  abort,
    input  logic                  scl,
    input  logic                  sda,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  finish,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    // Filtered lines and edge detection
    logic w_scl_f;
    logic w_sda_f;
    logic r_scl_f_d;
    logic r_sda_f_d;
    logic w_rise;
    logic w_fall;
    logic w_sda_chg;

    // State and datapath registers with their next values
    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_shift_in;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  r_finish;
    logic                  w_finish_next;
    logic                  r_error;
    logic                  w_error_next;
    logic [1:0]            r_code;
    logic [1:0]            w_code_next;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .i_clock    (clock),
        .i_reset_n  (reset_n),
        .i_raw      (scl),
        .o_filtered (w_scl_f)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .i_clock    (clock),
        .i_reset_n  (reset_n),
        .i_raw      (sda),
        .o_filtered (w_sda_f)
    );

    assign w_rise    =  w_scl_f & ~r_scl_f_d;
    assign w_fall    = ~w_scl_f &  r_scl_f_d;
    assign w_sda_chg =  w_sda_f ^  r_sda_f_d;

    // Shift register with the new bit inserted at the configured end.
    // The single-bit case is split out so no zero-width slice is formed.
    generate
        if (DATA_WIDTH == 1) begin : g_shift_single
            assign w_shift_in = w_sda_f;
        end else if (MSB_FIRST != 0) begin : g_shift_msb
            assign w_shift_in = {r_shift[DATA_WIDTH-2:0], w_sda_f};
        end else begin : g_shift_lsb
            assign w_shift_in = {w_sda_f, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_scl_f_d <= 1'b1;
            r_sda_f_d <= 1'b1;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_finish  <= 1'b0;
            r_error   <= 1'b0;
            r_code    <= ERR_NONE;
        end else begin
            r_state   <= w_state_next;
            r_scl_f_d <= w_scl_f;
            r_sda_f_d <= w_sda_f;
            r_shift   <= w_shift_next;
            r_cnt     <= w_cnt_next;
            r_data    <= w_data_next;
            r_finish  <= w_finish_next;
            r_error   <= w_error_next;
            r_code    <= w_code_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_cnt_next    = r_cnt;
        w_data_next   = r_data;
        w_finish_next = 1'b0;
        w_error_next  = r_error;
        w_code_next   = r_code;

        if (abort) begin
            // Abort overrides everything: leave data and error untouched.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        w_state_next = ST_ARMED;
                        w_error_next = 1'b0;
                        w_code_next  = ERR_NONE;
                        w_cnt_next   = '0;
                        w_shift_next = '0;
                    end
                end
                ST_ARMED, ST_LOW: begin
                    if (w_rise) begin
                        w_shift_next = w_shift_in;
                        if (r_cnt != CNT_FULL) begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                        w_state_next = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // An SCL fall takes priority: SDA may legally move with it.
                    if (w_fall) begin
                        if (r_cnt == CNT_FULL) begin
                            w_state_next  = ST_IDLE;
                            w_data_next   = r_shift;
                            w_finish_next = 1'b1;
                        end else begin
                            w_state_next = ST_LOW;
                        end
                    end else if (w_sda_chg) begin
                        w_state_next  = ST_IDLE;
                        w_finish_next = 1'b1;
                        w_error_next  = 1'b1;
                        w_code_next   = w_sda_f ? ERR_STOP : ERR_START;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign finish     = r_finish;
    assign error      = r_error;
    assign error_code = r_code;
    assign busy       = (r_state != ST_IDLE);

endmodule : i2c_slave_read_word

// File: doc/i2c_slave_read_word.md
I2C_SLAVE_READ_WORD -- requirements
Module: i2c_slave_read_word

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of bits per transfer (legal 1..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in data[DATA_WIDTH-1]; 0 = first bit lands in data[0].
REQ-003 SHALL have parameter FILTER_LEN, default 3: consecutive equal raw samples required before a filtered line changes (legal 1..15; 1 = no filtering).
REQ-004 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, one-cycle arm request; accepted only in IDLE.
REQ-007 SHALL have port abort, input, 1, synchronous return to IDLE with no finish pulse.
REQ-008 SHALL have ports scl and sda, input, 1 each, raw I2C lines.
REQ-009 SHALL have port data, output, DATA_WIDTH, last completed word.
REQ-010 SHALL have port finish, output, 1, one-cycle pulse at end of transfer (success or error).
REQ-011 SHALL have port error, output, 1, registered flag: last transfer ended abnormally.
REQ-012 SHALL have port error_code, output, 2, 00 none, 01 START seen, 10 STOP seen, 11 reserved.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 Filters: filtered scl_f/sda_f SHALL take a raw value only after FILTER_LEN consecutive identical samples; reset value 1.
REQ-015 Edges: rise = scl_f & ~scl_f_d, fall = ~scl_f & scl_f_d, scl_f_d being scl_f delayed one cycle (reset 1).
REQ-016 FSM states SHALL be IDLE, ARMED, HIGH, LOW.
REQ-017 IDLE + enable: go to ARMED; clear error, error_code, bit counter, shift register.
REQ-018 ARMED or LOW + rise: shift sda_f into shift register per MSB_FIRST; increment bit counter; go to HIGH.
REQ-019 HIGH + sda_f change without fall: go to IDLE, finish=1, error=1, error_code=01 if sda_f fell, 10 if it rose; data unchanged.
REQ-020 HIGH + fall, counter < DATA_WIDTH: go to LOW.
REQ-021 HIGH + fall, counter == DATA_WIDTH: go to IDLE, data <= shift register, finish=1 in the same cycle data updates, error stays 0.
REQ-022 Simultaneous fall and sda_f change in HIGH SHALL be treated as fall (data change at scl falling edge is legal).
REQ-023 abort SHALL win over every other event in the cycle; no finish pulse, error and data unchanged.
REQ-024 enable outside IDLE SHALL be ignored.
REQ-025 Bit counter SHALL be clog2(DATA_WIDTH+1) bits wide and never wrap.
REQ-026 Latency: raw scl rise to sample = FILTER_LEN+1 cycles; last fall to finish = FILTER_LEN+1 cycles.

Reset
REQ-027 On reset_n low: state IDLE, data 0, finish 0, error 0, error_code 00, busy 0, counter 0, filters and scl_f_d 1.
REQ-028 Reset asserted mid-transfer SHALL discard the partial word with no finish pulse.

Structure
REQ-029 Package i2c_pkg SHALL hold FSM state encoding and error_code constants (ERR_NONE, ERR_START, ERR_STOP).
REQ-030 Sub-module i2c_line_filter (parameter FILTER_LEN) SHALL be instantiated twice, once for scl and once for sda.

Verification
REQ-031 DATA_WIDTH=8, MSB_FIRST=1: enable, clock 0xA5 on clean bus -> data=0xA5, one finish pulse, error=0.
REQ-032 MSB_FIRST=0: same 0xA5 bit sequence -> data=0xA5 bit-reversed = 0xA5 check with 0x01 sequence -> data=0x80.
REQ-033 sda falls while scl high after bit 3 -> finish pulse, error=1, error_code=01, data keeps previous word.
REQ-034 FILTER_LEN=3: 2-cycle scl glitches during LOW -> no extra bit sampled, word 0x3C received intact.
REQ-035 abort after bit 5, then enable and 0x81 -> no finish for aborted word, data=0x81.
REQ-036 reset_n pulsed after bit 4 -> all outputs at reset values, no finish pulse, next enable works normally.
